kp_tune_ctrl: RTL and testbench

Sequencer that closes the gain-adaptation loop around the neural-net gain algorithm: it owns the kp register, presents kp to the algorithm, waits for the averaging filters to settle, samples the algorithm's ±1 step decision on each fresh phase measurement, and applies it with saturation. It declares lock when the step direction dithers and stops on an iteration limit. It sits between the PLL phase-measurement logic (n, n_valid) and the gain-algorithm datapath (kp in, inc out).

---
 rtl/kp_tune_pkg.sv | 31 +++
 rtl/kp_tune_ctrl_if.sv | 27 ++
 rtl/kp_sat_add.sv | 16 +
 rtl/kp_tune_ctrl.sv | 150 +++++++++++++++
 tb/tb_kp_tune_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kp_tune_pkg.sv
// Shared types and saturating gain arithmetic for the kp tuning sequencer.
// Combinational helpers only; no latency, no flow control.
package kp_tune_pkg;

  typedef logic [7:0] gain_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_UPDATE,
    ST_LOCKED,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DN
  } dir_t;

  // Unsigned gain plus signed step, clamped to [lo, hi]; wide enough that no sum wraps.
  function automatic gain_t sat_add(gain_t a, logic [7:0] b, gain_t lo, gain_t hi);
    logic signed [9:0] sum;
    sum = $signed({2'b00, a}) + $signed({{2{b[7]}}, b});
    if (sum < $signed({2'b00, lo})) return lo;
    if (sum > $signed({2'b00, hi})) return hi;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/kp_tune_ctrl_if.sv
// Command/status bundle between the gain-algorithm side and the kp sequencer.
// Wires only; strobes are single-cycle, no backpressure.
interface kp_tune_ctrl_if;
  import kp_tune_pkg::*;

  logic       start;
  logic       abort;
  gain_t      kp_init;
  logic       n_valid;
  logic [7:0] inc;
  gain_t      kp;
  logic       busy;
  logic       locked;
  logic       done;
  logic       timeout;

  modport master (
    output start, abort, kp_init, n_valid, inc,
    input  kp, busy, locked, done, timeout
  );

  modport slave (
    input  start, abort, kp_init, n_valid, inc,
    output kp, busy, locked, done, timeout
  );

endinterface

// File: rtl/kp_sat_add.sv
// Saturating kp adder: y = clamp(a + sext(b), LO, HI).
// Purely combinational; no flow control.
module kp_sat_add
  import kp_tune_pkg::*;
#(
  parameter gain_t LO = 8'd1,
  parameter gain_t HI = 8'd254
) (
  input  gain_t      a,
  input  logic [7:0] b,
  output gain_t      y
);

  assign y = sat_add(a, b, LO, HI);

endmodule

// File: rtl/kp_tune_ctrl.sv
// kp adaptation sequencer: settle, sample a +/-1 step on n_valid, apply with clamp, detect lock/timeout.
// Latency: kp visible 1 cycle after start/UPDATE; iteration period SETTLE_CYC+2 cycles minimum.
// Backpressure: none; SAMPLE simply waits on n_valid, strobes outside SAMPLE are dropped.
module kp_tune_ctrl
  import kp_tune_pkg::*;
#(
  parameter int    SETTLE_CYC = 16,
  parameter gain_t KP_MIN     = 8'd1,
  parameter gain_t KP_MAX     = 8'd254,
  parameter int    LOCK_FLIPS = 4,
  parameter int    MAX_ITER   = 200
) (
  input logic           clk,
  input logic           rst_n,
  kp_tune_ctrl_if.slave bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] LOCK_N      = 4'(LOCK_FLIPS);
  localparam logic [7:0] ITER_N      = 8'(MAX_ITER);

  state_t     state_q, state_d;
  gain_t      kp_q, kp_d;
  logic [7:0] settle_q, settle_d;
  logic [7:0] iter_q, iter_d;
  logic [3:0] flip_q, flip_d;
  dir_t       prev_q, prev_d;
  logic [7:0] inc_q, inc_d;
  logic       done_q, done_d;

  gain_t      sat_a, sat_y;
  logic [7:0] sat_b;
  dir_t       dir;
  logic [3:0] flip_nxt;
  logic [7:0] iter_nxt;

  // One adder serves both the kp_init clamp on start and the step in UPDATE.
  assign sat_a = (state_q == ST_UPDATE) ? kp_q  : bus.kp_init;
  assign sat_b = (state_q == ST_UPDATE) ? inc_q : 8'h00;

  kp_sat_add #(.LO(KP_MIN), .HI(KP_MAX)) u_sat (
    .a (sat_a),
    .b (sat_b),
    .y (sat_y)
  );

  always_comb begin
    dir = DIR_NONE;
    if (inc_q != 8'h00) dir = inc_q[7] ? DIR_DN : DIR_UP;
  end

  // A zero step breaks the dither chain: it neither counts nor seeds a reversal.
  assign flip_nxt = (dir != DIR_NONE && prev_q != DIR_NONE && dir != prev_q) ?
                    flip_q + 4'd1 : 4'd0;
  assign iter_nxt = iter_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    kp_d     = kp_q;
    settle_d = settle_q;
    iter_d   = iter_q;
    flip_d   = flip_q;
    prev_d   = prev_q;
    inc_d    = inc_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOCKED, ST_DONE: begin
        if (bus.start) begin
          kp_d     = sat_y;
          iter_d   = 8'd0;
          flip_d   = 4'd0;
          prev_d   = DIR_NONE;
          settle_d = 8'd0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 8'd0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_SAMPLE: begin
        if (bus.n_valid) begin
          inc_d   = bus.inc;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        kp_d     = sat_y;
        iter_d   = iter_nxt;
        flip_d   = flip_nxt;
        prev_d   = dir;
        settle_d = 8'd0;
        if (flip_nxt == LOCK_N) begin
          state_d = ST_LOCKED;
          done_d  = 1'b1;
        end else if (iter_nxt == ITER_N) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) begin
      state_d  = ST_IDLE;
      kp_d     = kp_q;
      settle_d = 8'd0;
      iter_d   = 8'd0;
      flip_d   = 4'd0;
      prev_d   = DIR_NONE;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      kp_q     <= KP_MIN;
      settle_q <= 8'd0;
      iter_q   <= 8'd0;
      flip_q   <= 4'd0;
      prev_q   <= DIR_NONE;
      inc_q    <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kp_q     <= kp_d;
      settle_q <= settle_d;
      iter_q   <= iter_d;
      flip_q   <= flip_d;
      prev_q   <= prev_d;
      inc_q    <= inc_d;
      done_q   <= done_d;
    end
  end

  assign bus.kp      = kp_q;
  assign bus.busy    = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE) || (state_q == ST_UPDATE);
  assign bus.locked  = (state_q == ST_LOCKED);
  assign bus.done    = done_q;
  assign bus.timeout = (state_q == ST_DONE);

endmodule

// File: tb/tb_kp_tune_ctrl.sv
// Bench for kp_tune_ctrl: directed vector table, fixed-timing tuning runs, and random traffic
// checked every cycle against an event-level model of the tuning loop.
module tb_kp_tune_ctrl;

  localparam int SETTLE_CYC = 16;
  localparam int KP_MIN     = 1;
  localparam int KP_MAX     = 254;
  localparam int LOCK_FLIPS = 4;
  localparam int MAX_ITER   = 200;

  logic clk;
  logic rst_n;

  kp_tune_ctrl_if bus ();

  kp_tune_ctrl #(
    .SETTLE_CYC (SETTLE_CYC),
    .KP_MIN     (8'(KP_MIN)),
    .KP_MAX     (8'(KP_MAX)),
    .LOCK_FLIPS (LOCK_FLIPS),
    .MAX_ITER   (MAX_ITER)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: a run is "eligible" to accept a sample from cycle m_elig on.
  int m_kp, m_iter, m_flips, m_prev, m_elig, m_pinc, m_cyc;
  bit m_run, m_lock, m_to, m_done, m_pend;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): actual %0d, required %0d", name, m_cyc, act, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < KP_MIN) return KP_MIN;
    if (v > KP_MAX) return KP_MAX;
    return v;
  endfunction

  task automatic model_reset();
    m_kp = KP_MIN; m_iter = 0; m_flips = 0; m_prev = 0; m_elig = 0; m_pinc = 0;
    m_run = 0; m_lock = 0; m_to = 0; m_done = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input logic [7:0] ki,
                            input bit nv, input logic [7:0] ic);
    int dir;
    m_done = 0;
    if (a) begin
      m_run = 0; m_lock = 0; m_to = 0; m_pend = 0;
    end else if (m_pend) begin
      m_kp = clampi(m_kp + m_pinc);
      dir  = (m_pinc > 0) ? 1 : (m_pinc < 0) ? -1 : 0;
      if (dir != 0 && m_prev != 0 && dir != m_prev) m_flips++;
      else m_flips = 0;
      m_prev = dir;
      m_iter++;
      m_pend = 0;
      if (m_flips == LOCK_FLIPS) begin
        m_run = 0; m_lock = 1; m_done = 1;
      end else if (m_iter == MAX_ITER) begin
        m_run = 0; m_to = 1; m_done = 1;
      end else begin
        m_elig = m_cyc + 1 + SETTLE_CYC;
      end
    end else if (m_run) begin
      if (nv && m_cyc >= m_elig) begin
        m_pend = 1;
        m_pinc = int'($signed(ic));
      end
    end else if (s) begin
      m_kp = clampi(int'(ki));
      m_iter = 0; m_flips = 0; m_prev = 0;
      m_run = 1; m_lock = 0; m_to = 0;
      m_elig = m_cyc + 1 + SETTLE_CYC;
    end
    m_cyc++;
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs to the model.
  task automatic cyc(input bit s, input bit a, input logic [7:0] ki,
                     input bit nv, input logic [7:0] ic);
    bus.start = s; bus.abort = a; bus.kp_init = ki; bus.n_valid = nv; bus.inc = ic;
    model_step(s, a, ki, nv, ic);
    @(posedge clk);
    #1;
    chk("model_kp",      int'(bus.kp),      m_kp);
    chk("model_busy",    int'(bus.busy),    int'(m_run));
    chk("model_locked",  int'(bus.locked),  int'(m_lock));
    chk("model_done",    int'(bus.done),    int'(m_done));
    chk("model_timeout", int'(bus.timeout), int'(m_to));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'd0, 0, 8'h00);
  endtask

  int seq_inc[256];
  int seq_kp[256];

  // Start a run and feed one sample exactly in the first SAMPLE cycle of each iteration.
  task automatic run_seq(input string name, input logic [7:0] ki, input int n, input bit exp_lock);
    cyc(1, 0, ki, 0, 8'h00);
    for (int k = 0; k < n; k++) begin
      idle(SETTLE_CYC);
      cyc(0, 0, 8'd0, 1, 8'(seq_inc[k]));
      idle(1);
      chk({name, "_kp"}, int'(bus.kp), seq_kp[k]);
      chk({name, "_done"}, int'(bus.done), (k == n - 1) ? 1 : 0);
    end
    chk({name, "_locked"},  int'(bus.locked),  int'(exp_lock));
    chk({name, "_timeout"}, int'(bus.timeout), int'(!exp_lock));
    chk({name, "_busy"},    int'(bus.busy),    0);
    idle(1);
    chk({name, "_done_once"}, int'(bus.done), 0);
    chk({name, "_kp_held"},   int'(bus.kp),   seq_kp[n-1]);
  endtask

  typedef struct {
    bit         s;
    bit         a;
    logic [7:0] ki;
    bit         nv;
    logic [7:0] ic;
    int         rep;
    int         e_kp;
    bit         e_busy;
    bit         e_lock;
    bit         e_done;
    bit         e_to;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 0, 8'd50,  0, 8'h00, 1,  50,  1, 0, 0, 0}; // start
    tbl[1]  = '{0, 0, 8'd0,   0, 8'h00, 4,  50,  1, 0, 0, 0};
    tbl[2]  = '{0, 0, 8'd0,   1, 8'h01, 1,  50,  1, 0, 0, 0}; // early strobe, dropped
    tbl[3]  = '{0, 0, 8'd0,   0, 8'h00, 10, 50,  1, 0, 0, 0};
    tbl[4]  = '{0, 0, 8'd0,   1, 8'h01, 1,  50,  1, 0, 0, 0}; // last settle cycle, dropped
    tbl[5]  = '{0, 0, 8'd0,   1, 8'hFF, 1,  50,  1, 0, 0, 0}; // first sample cycle
    tbl[6]  = '{0, 0, 8'd0,   1, 8'h01, 1,  49,  1, 0, 0, 0}; // update cycle
    tbl[7]  = '{0, 0, 8'd0,   0, 8'h00, 16, 49,  1, 0, 0, 0};
    tbl[8]  = '{1, 1, 8'd0,   0, 8'h00, 1,  49,  0, 0, 0, 0}; // abort beats start
    tbl[9]  = '{0, 0, 8'd0,   1, 8'h01, 2,  49,  0, 0, 0, 0};
    tbl[10] = '{1, 0, 8'd0,   0, 8'h00, 1,  1,   1, 0, 0, 0}; // low clamp
    tbl[11] = '{0, 1, 8'd0,   0, 8'h00, 1,  1,   0, 0, 0, 0};
    tbl[12] = '{1, 0, 8'd255, 0, 8'h00, 1,  254, 1, 0, 0, 0}; // high clamp
    tbl[13] = '{0, 1, 8'd0,   0, 8'h00, 1,  254, 0, 0, 0, 0};

    bus.start = 0; bus.abort = 0; bus.kp_init = 0; bus.n_valid = 0; bus.inc = 0;
    m_cyc = 0;
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_kp",      int'(bus.kp),      KP_MIN);
    chk("rst_busy",    int'(bus.busy),    0);
    chk("rst_locked",  int'(bus.locked),  0);
    chk("rst_done",    int'(bus.done),    0);
    chk("rst_timeout", int'(bus.timeout), 0);
    rst_n = 1;

    // Reset asserted in the middle of SETTLE.
    cyc(1, 0, 8'd77, 0, 8'h00);
    idle(5);
    chk("pre_rst_kp", int'(bus.kp), 77);
    rst_n = 0;
    #1;
    chk("midrst_kp",     int'(bus.kp),     KP_MIN);
    chk("midrst_busy",   int'(bus.busy),   0);
    chk("midrst_locked", int'(bus.locked), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;

    for (int i = 0; i < NV; i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        cyc(tbl[i].s, tbl[i].a, tbl[i].ki, tbl[i].nv, tbl[i].ic);
        chk($sformatf("tbl%0d_kp", i),      int'(bus.kp),      tbl[i].e_kp);
        chk($sformatf("tbl%0d_busy", i),    int'(bus.busy),    int'(tbl[i].e_busy));
        chk($sformatf("tbl%0d_locked", i),  int'(bus.locked),  int'(tbl[i].e_lock));
        chk($sformatf("tbl%0d_done", i),    int'(bus.done),    int'(tbl[i].e_done));
        chk($sformatf("tbl%0d_timeout", i), int'(bus.timeout), int'(tbl[i].e_to));
      end
    end

    // Dither lock: five alternating steps, lock on the fourth reversal.
    seq_inc[0] = 1; seq_inc[1] = 255; seq_inc[2] = 1; seq_inc[3] = 255; seq_inc[4] = 1;
    seq_kp[0] = 101; seq_kp[1] = 100; seq_kp[2] = 101; seq_kp[3] = 100; seq_kp[4] = 101;
    run_seq("lock", 8'd100, 5, 1);

    // A zero step clears the reversal chain, so lock takes nine updates.
    seq_inc[0] = 1; seq_inc[1] = 255; seq_inc[2] = 1; seq_inc[3] = 0; seq_inc[4] = 255;
    seq_inc[5] = 1; seq_inc[6] = 255; seq_inc[7] = 1; seq_inc[8] = 255;
    seq_kp[0] = 101; seq_kp[1] = 100; seq_kp[2] = 101; seq_kp[3] = 101; seq_kp[4] = 100;
    seq_kp[5] = 101; seq_kp[6] = 100; seq_kp[7] = 101; seq_kp[8] = 100;
    run_seq("zero", 8'd100, 9, 1);

    // Monotonic climb into the upper clamp until the iteration limit.
    for (int k = 0; k < MAX_ITER; k++) begin
      seq_inc[k] = 1;
      seq_kp[k]  = (250 + k + 1 > KP_MAX) ? KP_MAX : 250 + k + 1;
    end
    run_seq("climb", 8'd250, MAX_ITER, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit         s, a, nv;
      logic [7:0] ic;
      int         r;
      s  = ($urandom_range(0, 39) == 0);
      a  = ($urandom_range(0, 299) == 0);
      nv = ($urandom_range(0, 2) == 0);
      r  = $urandom_range(0, 9);
      if (r < 4)       ic = 8'h01;
      else if (r < 8)  ic = 8'hFF;
      else if (r == 8) ic = 8'h00;
      else             ic = 8'($urandom);
      cyc(s, a, 8'($urandom), nv, ic);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
